fib_index: RTL

FIB_INDEX -- requirements
Module: fib_index

---
 rtl/fib_pkg.sv | 18 +
 rtl/fib_index_if.sv | 37 +++
 rtl/fib_step.sv | 25 ++
 rtl/fib_index.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci index decoder.
//   state_e    : controller states (IDLE, UP, DOWN)
//   IDX_W      : width of the Fibonacci index outputs
//   MAX_IDX_32 : largest index whose F(n) fits in 32 bits
//   F47_32     : F(47), the largest Fibonacci number below 2^32
package fib_pkg;

    typedef enum logic [1:0] {
        IDLE,
        UP,
        DOWN
    } state_e;

    localparam int unsigned IDX_W      = 7;
    localparam int unsigned MAX_IDX_32 = 47;
    localparam logic [31:0] F47_32     = 32'd2971215073;

endpackage

// File: rtl/fib_index_if.sv
// Request/result bundle for fib_index.
//   start, v                 : request (master drives)
//   done, n, fibn, exact     : status and results (slave drives)
//   zeck                     : Zeckendorf mask, only when FIB_INDEX_ZECK_EN is defined
interface fib_index_if
    import fib_pkg::*;
#(
    parameter int unsigned W  = 32,
    parameter int unsigned ZW = 48
);
    logic             start;
    logic [W-1:0]     v;
    logic             done;
    logic [IDX_W-1:0] n;
    logic [W-1:0]     fibn;
    logic             exact;
`ifdef FIB_INDEX_ZECK_EN
    logic [ZW-1:0]    zeck;
`endif

    modport master (
`ifdef FIB_INDEX_ZECK_EN
        input  zeck,
`endif
        output start, v,
        input  done, n, fibn, exact
    );

    modport slave (
`ifdef FIB_INDEX_ZECK_EN
        output zeck,
`endif
        input  start, v,
        output done, n, fibn, exact
    );

endinterface

// File: rtl/fib_step.sv
// Combinational Fibonacci pair step.
//   a, b        : current pair (F(k), F(k+1))
//   sum, carry  : forward step b' = a + b, carry out of bit W-1
//   diff        : reverse step a' = b - a (only with FIB_INDEX_ZECK_EN)
// The forward a' = b and reverse b' = a are plain wires in the caller.
module fib_step #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
`ifdef FIB_INDEX_ZECK_EN
    output logic [W-1:0] diff,
`endif
    output logic [W-1:0] sum,
    output logic         carry
);

    assign {carry, sum} = {1'b0, a} + {1'b0, b};

`ifdef FIB_INDEX_ZECK_EN
    // Modular subtraction recovers F(k-1) even if b wrapped during the climb.
    assign diff = b - a;
`endif

endmodule

// File: rtl/fib_index.sv
// Fibonacci index decoder: finds the largest n with F(n) <= v.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fib_index_if slave (start/v in; done/n/fibn/exact out)
// Optional macro FIB_INDEX_ZECK_EN adds the DOWN phase that builds the
// Zeckendorf mask on bus.zeck by greedy subtraction.
module fib_index
    import fib_pkg::*;
#(
    parameter int unsigned W  = 32,
    parameter int unsigned ZW = 48
) (
    input  logic        clk,
    input  logic        rst,
    fib_index_if.slave  bus
);

    state_e           state_q, state_d;
    logic [W-1:0]     v_q, v_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic             b_ovf_q, b_ovf_d;  // b exceeded W bits, i.e. b > v
    logic [IDX_W-1:0] k_q, k_d;
    logic [IDX_W-1:0] n_q, n_d;
    logic [W-1:0]     fibn_q, fibn_d;
    logic             exact_q, exact_d;
`ifdef FIB_INDEX_ZECK_EN
    logic [W-1:0]     rem_q, rem_d;
    logic [W-1:0]     rem_nxt;
    logic [ZW-1:0]    zeck_q, zeck_d;
    logic [W-1:0]     diff;
`endif
    logic [W-1:0]     sum;
    logic             carry;

    fib_step #(
        .W (W)
    ) u_step (
        .a     (a_q),
        .b     (b_q),
`ifdef FIB_INDEX_ZECK_EN
        .diff  (diff),
`endif
        .sum   (sum),
        .carry (carry)
    );

    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        a_d     = a_q;
        b_d     = b_q;
        b_ovf_d = b_ovf_q;
        k_d     = k_q;
        n_d     = n_q;
        fibn_d  = fibn_q;
        exact_d = exact_q;
`ifdef FIB_INDEX_ZECK_EN
        rem_d   = rem_q;
        rem_nxt = rem_q;
        zeck_d  = zeck_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    v_d     = bus.v;
                    a_d     = '0;
                    b_d     = W'(1);
                    b_ovf_d = 1'b0;
                    k_d     = '0;
                    exact_d = 1'b0;
`ifdef FIB_INDEX_ZECK_EN
                    zeck_d  = '0;
`endif
                    state_d = UP;
                end
            end
            UP: begin
                if (!b_ovf_q && (b_q <= v_q)) begin
                    a_d     = b_q;
                    b_d     = sum;
                    b_ovf_d = carry;
                    k_d     = k_q + IDX_W'(1);
                end else begin
                    n_d     = k_q;
                    fibn_d  = a_q;
                    exact_d = (a_q == v_q);
`ifdef FIB_INDEX_ZECK_EN
                    if (v_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        rem_d   = v_q;
                        state_d = DOWN;
                    end
`else
                    state_d = IDLE;
`endif
                end
            end
`ifdef FIB_INDEX_ZECK_EN
            DOWN: begin
                if ((k_q >= IDX_W'(2)) && (a_q <= rem_q)) begin
                    for (int i = 0; i < ZW; i++) begin
                        if (k_q == IDX_W'(i)) zeck_d[i] = 1'b1;
                    end
                    rem_nxt = rem_q - a_q;
                end
                rem_d   = rem_nxt;
                a_d     = diff;
                b_d     = a_q;
                b_ovf_d = 1'b0;
                k_d     = k_q - IDX_W'(1);
                // Done once nothing remains or the step just taken used k=2.
                if ((rem_nxt == '0) || (k_q < IDX_W'(3))) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            v_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            b_ovf_q <= 1'b0;
            k_q     <= '0;
            n_q     <= '0;
            fibn_q  <= '0;
            exact_q <= 1'b0;
`ifdef FIB_INDEX_ZECK_EN
            rem_q   <= '0;
            zeck_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            a_q     <= a_d;
            b_q     <= b_d;
            b_ovf_q <= b_ovf_d;
            k_q     <= k_d;
            n_q     <= n_d;
            fibn_q  <= fibn_d;
            exact_q <= exact_d;
`ifdef FIB_INDEX_ZECK_EN
            rem_q   <= rem_d;
            zeck_q  <= zeck_d;
`endif
        end
    end

    assign bus.done  = (state_q == IDLE);
    assign bus.n     = n_q;
    assign bus.fibn  = fibn_q;
    assign bus.exact = exact_q;
`ifdef FIB_INDEX_ZECK_EN
    assign bus.zeck  = zeck_q;
`endif

endmodule
